clk_switch_ctrl: RTL and testbench
==================================

# clk_switch_ctrl

Parametrised N-way clock-source switch controller for the SoC clocking subsystem. It runs on one always-on reference clock. It accepts source-select requests over a valid/ready handshake and sequences per-source clock enables break-before-make, which drive the downstream per-source clock gates and glitchless muxes. It also checks source health and falls back to the previous source on timeout. It generalises the fixed two-input, select-only switch to NUM_CLK sources with programmable drain and settle intervals, status reporting and error recovery.

## Interface

Parameters:
- NUM_CLK, 4, number of clock sources (2..16)
- SEL_W, 2, select width; 2^SEL_W >= NUM_CLK
- DEFAULT_SEL, 0, source enabled out of reset (< NUM_CLK)
- OFF_CYCLES, 8, all-enables-low drain interval (>= 1)
- ON_CYCLES, 4, settle interval after enabling the new source (>= 1)
- TIMEOUT, 64, maximum wait for target CLK_OK (>= 1)

Ports:
- Clocking: one clock, CLK; reset RESET is synchronous and active-high.
- CLK, in, 1, always-on reference clock; all logic on rising edge
- RESET, in, 1, synchronous active-high reset
- REQ_VALID, in, 1, switch request valid
- REQ_SEL, in, SEL_W, requested source index
- REQ_READY, out, 1, controller idle; request accepted when REQ_VALID && REQ_READY
- CLK_OK, in, NUM_CLK, per-source health (PLL lock etc.), already synchronised to CLK
- CLK_EN, out, NUM_CLK, per-source enable; one-hot or all-zero
- CUR_SEL, out, SEL_W, currently enabled source index
- SWITCHING, out, 1, sequence in progress
- DONE, out, 1, one-cycle pulse at sequence completion
- ERR, out, 1, one-cycle pulse on invalid request or timeout fallback

## Operation

- Reset values: CLK_EN = one-hot(DEFAULT_SEL); CUR_SEL = DEFAULT_SEL; REQ_READY = 1; SWITCHING = DONE = ERR = 0; state IDLE; counters 0.
- RESET asserted mid-sequence returns the outputs to the reset values on the next edge.
- Invariant: CLK_EN never has more than one bit set in any cycle.
- Invariant: between deasserting one enable and asserting another, all bits are zero for at least OFF_CYCLES cycles.

State machine:
- IDLE, accept with REQ_SEL >= NUM_CLK: ERR pulse next cycle; stay in IDLE; no enable change.
- IDLE, accept with REQ_SEL == CUR_SEL: DONE pulse next cycle; stay in IDLE; no enable change.
- IDLE, any other accept: latch target and prev = CUR_SEL, clear CLK_EN, go to OFF.
- OFF: hold for OFF_CYCLES cycles, then go to WAIT_OK.
- WAIT_OK: if CLK_OK[target] is sampled high, set CLK_EN[target], set CUR_SEL = target, go to ON.
- WAIT_OK: after TIMEOUT cycles without CLK_OK[target], set target = prev, set the fallback flag, set CLK_EN[prev], set CUR_SEL = prev, go to ON. CLK_OK[prev] is not checked.
- ON: hold for ON_CYCLES cycles, then go to FIN.
- FIN: one cycle; DONE = 1; ERR = fallback flag; clear the flag; go to IDLE.
- REQ_READY = 1 only in IDLE. SWITCHING = 1 in OFF, WAIT_OK and ON.
- Requests presented while REQ_READY = 0 are ignored; the requester holds REQ_VALID.
- CLK_OK deasserting during ON or IDLE does not affect the block. Health monitoring is the requester's job.
- Counter width: clog2(max(OFF_CYCLES, ON_CYCLES, TIMEOUT) + 1). Counters reload to 0 on every state entry, with no wrap.

## Timing

- Acceptance edge is T.
- T+1: CLK_EN = 0, SWITCHING = 1, REQ_READY = 0.
- CLK_EN stays zero through T+OFF_CYCLES+1. This is one WAIT_OK cycle on top of the drain.
- CLK_OK[target] high on arrival: CLK_EN[target] = 1 at T+OFF_CYCLES+2, with CUR_SEL updated the same cycle.
- DONE and REQ_READY = 1 at T+OFF_CYCLES+ON_CYCLES+2, with SWITCHING = 0. With defaults this is T+14.
- Each WAIT_OK cycle spent waiting delays CLK_EN and DONE by one cycle.
- Timeout case: CLK_EN[prev] = 1 at T+OFF_CYCLES+TIMEOUT+1; DONE and ERR at T+OFF_CYCLES+TIMEOUT+ON_CYCLES+1.
- Back-to-back: a new request may be accepted on the DONE cycle, because REQ_READY = 1 there.

## Test plan

- Reset and switch: hold CLK_OK = 4'b1111 after reset; check CLK_EN = 4'b0001. Request 2 at T; check:
  - CLK_EN = 0 for T+1..T+9;
  - CLK_EN = 4'b0100 and CUR_SEL = 2 at T+10;
  - DONE at T+14.
- Same-source request: request 2 while CUR_SEL = 2 -> DONE at T+1 and CLK_EN unchanged.
- Invalid request: request 5 with SEL_W = 3 and NUM_CLK = 4 -> ERR at T+1, no DONE, CLK_EN unchanged.
- Timeout fallback: from source 0, request 3 with CLK_OK[3] = 0 -> CLK_EN = 0 for 72 cycles, CLK_EN = 4'b0001 at T+73, DONE and ERR at T+77, CUR_SEL = 0.
- Late health: request 1 with CLK_OK[1] rising 20 cycles into WAIT_OK -> CLK_EN[1] one cycle after the rise; no ERR.
- Reset mid-sequence: RESET at T+5 during OFF -> CLK_EN = 4'b0001, REQ_READY = 1, SWITCHING = 0 at the next edge.
- Throughout all scenarios, a one-hot and break-before-make assertion checker is active.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: N-way clock-source switch sequencer. Drops every per-source
// enable and drains for a fixed interval, waits for the new source to report
// healthy, then enables it and lets it settle. If the new source never becomes
// healthy, the controller falls back to the previous source and flags an error.
module clk_switch_ctrl #(
  parameter int NUM_CLK     = 4,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_SEL = 0,
  parameter int OFF_CYCLES  = 8,
  parameter int ON_CYCLES   = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               REQ_VALID,
  input  logic [SEL_W-1:0]   REQ_SEL,
  output logic               REQ_READY,
  input  logic [NUM_CLK-1:0] CLK_OK,
  output logic [NUM_CLK-1:0] CLK_EN,
  output logic [SEL_W-1:0]   CUR_SEL,
  output logic               SWITCHING,
  output logic               DONE,
  output logic               ERR
);

  localparam int MAX_A   = (OFF_CYCLES > ON_CYCLES) ? OFF_CYCLES : ON_CYCLES;
  localparam int MAX_CNT = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_SEL);
  localparam logic [SEL_W:0]   NUM_SEL  = (SEL_W+1)'(NUM_CLK);

  typedef enum logic [1:0] {IDLE, OFF, WAIT_OK, ON} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [SEL_W-1:0]   target, target_nx;
  logic [SEL_W-1:0]   prev, prev_nx;
  logic [SEL_W-1:0]   cur, cur_nx;
  logic [NUM_CLK-1:0] en, en_nx;
  logic               fallback, fallback_nx;
  logic               done, done_nx;
  logic               err, err_nx;

  logic               accept;
  logic               req_bad;
  logic               tgt_ok;
  logic [NUM_CLK-1:0] tgt_mask;
  logic [NUM_CLK-1:0] prev_mask;

  // Shift-based one-hot decode avoids indexing CLK_OK with an over-wide select.
  assign tgt_mask  = NUM_CLK'(1) << target;
  assign prev_mask = NUM_CLK'(1) << prev;
  assign tgt_ok    = |(CLK_OK & tgt_mask);
  assign accept    = REQ_VALID && (state == IDLE);
  assign req_bad   = ({1'b0, REQ_SEL} >= NUM_SEL);

  // State, counter and registered outputs; reset restores the default source.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      target   <= DEF_SEL;
      prev     <= DEF_SEL;
      cur      <= DEF_SEL;
      en       <= NUM_CLK'(1) << DEF_SEL;
      fallback <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      target   <= target_nx;
      prev     <= prev_nx;
      cur      <= cur_nx;
      en       <= en_nx;
      fallback <= fallback_nx;
      done     <= done_nx;
      err      <= err_nx;
    end
  end

  // Next-state logic. DONE/ERR are registered pulses, so the completion pulse
  // lands on the first IDLE cycle, where a back-to-back request is accepted.
  always_comb begin
    state_nx    = state;
    cnt_nx      = '0;
    target_nx   = target;
    prev_nx     = prev;
    cur_nx      = cur;
    en_nx       = en;
    fallback_nx = fallback;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad) begin
            err_nx = 1'b1;
          end else if (REQ_SEL == cur) begin
            done_nx = 1'b1;
          end else begin
            target_nx = REQ_SEL;
            prev_nx   = cur;
            en_nx     = '0;
            state_nx  = OFF;
          end
        end
      end
      OFF: begin
        if (cnt == OFF_LAST) state_nx = WAIT_OK;
        else                 cnt_nx   = cnt + 1'b1;
      end
      WAIT_OK: begin
        if (tgt_ok) begin
          en_nx    = tgt_mask;
          cur_nx   = target;
          state_nx = ON;
        end else if (cnt == TO_LAST) begin
          // Previous source is trusted without checking its health.
          target_nx   = prev;
          fallback_nx = 1'b1;
          en_nx       = prev_mask;
          cur_nx      = prev;
          state_nx    = ON;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ON: begin
        if (cnt == ON_LAST) begin
          state_nx    = IDLE;
          done_nx     = 1'b1;
          err_nx      = fallback;
          fallback_nx = 1'b0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign REQ_READY = (state == IDLE);
  assign SWITCHING = (state != IDLE);
  assign CLK_EN    = en;
  assign CUR_SEL   = cur;
  assign DONE      = done;
  assign ERR       = err;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Testbench for clk_switch_ctrl: table of single-cycle idle requests, directed
// switch/timeout/late-health/reset sequences, then a random run compared
// against a timeline model built from the request/health traces.
module tb_clk_switch_ctrl;
  localparam int NUM_CLK = 4;
  localparam int SEL_W   = 3;
  localparam int DEF     = 0;
  localparam int OFFC    = 8;
  localparam int ONC     = 4;
  localparam int TO      = 64;
  localparam int N       = 2500;
  localparam int NA      = N + 120;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic               REQ_VALID = 1'b0;
  logic [SEL_W-1:0]   REQ_SEL = '0;
  logic               REQ_READY;
  logic [NUM_CLK-1:0] CLK_OK = 4'hF;
  logic [NUM_CLK-1:0] CLK_EN;
  logic [SEL_W-1:0]   CUR_SEL;
  logic               SWITCHING, DONE, ERR;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  clk_switch_ctrl #(
    .NUM_CLK(NUM_CLK), .SEL_W(SEL_W), .DEFAULT_SEL(DEF),
    .OFF_CYCLES(OFFC), .ON_CYCLES(ONC), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_SEL(REQ_SEL),
    .REQ_READY(REQ_READY), .CLK_OK(CLK_OK), .CLK_EN(CLK_EN), .CUR_SEL(CUR_SEL),
    .SWITCHING(SWITCHING), .DONE(DONE), .ERR(ERR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One-hot and break-before-make monitor; transitions caused by reset are excused.
  logic               armed = 1'b0;
  logic               rst_edge = 1'b0;
  int                 zero_run = 0;
  logic [NUM_CLK-1:0] last_en = '0;
  always @(posedge CLK) rst_edge <= RESET;
  always @(negedge CLK) begin
    if (armed) begin
      checks++;
      if ($countones(CLK_EN) > 1) begin
        errors++;
        $display("FAIL onehot actual=%b required=at-most-one-bit", CLK_EN);
      end else if (!rst_edge && CLK_EN != '0 && CLK_EN != last_en) begin
        if (last_en != '0) begin
          errors++;
          $display("FAIL bbm_swap actual=%b->%b required=zero gap", last_en, CLK_EN);
        end else if (zero_run < OFFC) begin
          errors++;
          $display("FAIL bbm_gap actual=%0d required>=%0d", zero_run, OFFC);
        end
      end
      zero_run = (CLK_EN == '0) ? zero_run + 1 : 0;
      last_en  = CLK_EN;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    REQ_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    armed = 1'b1;
  endtask

  // Accept a switch at T (current cycle) and check cycles T+1..T+done_k.
  task automatic run_switch(input string name, input int sel, input int tgt,
                            input int en_k, input int done_k, input logic exp_err,
                            input int rise_k);
    logic [NUM_CLK-1:0] tgt_en;
    tgt_en = 4'b0001 << tgt;
    chk({name, ".ready0"}, 32'(REQ_READY), 32'(1));
    REQ_VALID = 1'b1;
    REQ_SEL = SEL_W'(sel);
    for (int k = 1; k <= done_k; k++) begin
      @(negedge CLK);
      REQ_VALID = 1'b0;
      if (rise_k >= 0) CLK_OK[sel] = (k >= rise_k);
      if (k < en_k) chk($sformatf("%s.en[%0d]", name, k), 32'(CLK_EN), 32'(0));
      else begin
        chk($sformatf("%s.en[%0d]", name, k), 32'(CLK_EN), 32'(tgt_en));
        chk($sformatf("%s.cur[%0d]", name, k), 32'(CUR_SEL), 32'(tgt));
      end
      chk($sformatf("%s.done[%0d]", name, k), 32'(DONE), 32'(k == done_k));
      chk($sformatf("%s.err[%0d]", name, k), 32'(ERR), 32'((k == done_k) && exp_err));
      chk($sformatf("%s.sw[%0d]", name, k), 32'(SWITCHING), 32'(k < done_k));
      chk($sformatf("%s.rdy[%0d]", name, k), 32'(REQ_READY), 32'(k == done_k));
    end
  endtask

  typedef struct {
    logic               vld;
    logic [SEL_W-1:0]   sel;
    logic               done;
    logic               err;
    logic [NUM_CLK-1:0] en;
    logic [SEL_W-1:0]   cur;
  } vec_t;
  vec_t vecs[7];

  // Random traces and expected timeline.
  logic [NUM_CLK-1:0] ok_t[NA];
  logic               vld_t[NA];
  logic [SEL_W-1:0]   sel_t[NA];
  logic [NUM_CLK-1:0] exp_en[NA];
  logic [SEL_W-1:0]   exp_cur[NA];
  logic               exp_rdy[NA], exp_sw[NA], exp_done[NA], exp_err[NA];

  // Timeline model: each accepted switch occupies a computed span of cycles.
  task automatic build_model();
    int c, cur, s, w0, k, en_at, tgt, done_at;
    logic fb;
    for (int i = 0; i < NA; i++) begin
      exp_done[i] = 1'b0;
      exp_err[i]  = 1'b0;
    end
    cur = DEF;
    c = 0;
    while (c < N) begin
      exp_en[c]  = 4'b0001 << cur;
      exp_cur[c] = SEL_W'(cur);
      exp_rdy[c] = 1'b1;
      exp_sw[c]  = 1'b0;
      s = int'(sel_t[c]);
      if (vld_t[c] && s >= NUM_CLK) begin
        exp_err[c+1] = 1'b1;
        c++;
      end else if (vld_t[c] && s == cur) begin
        exp_done[c+1] = 1'b1;
        c++;
      end else if (vld_t[c]) begin
        w0 = c + OFFC + 1;
        k = -1;
        for (int j = 0; j < TO; j++)
          if (k < 0 && ok_t[w0+j][s]) k = j;
        if (k >= 0) begin en_at = w0 + k + 1; tgt = s;   fb = 1'b0; end
        else        begin en_at = w0 + TO;    tgt = cur; fb = 1'b1; end
        done_at = en_at + ONC;
        for (int d = c + 1; d < done_at; d++) begin
          exp_en[d]  = (d < en_at) ? 4'b0000 : (4'b0001 << tgt);
          exp_cur[d] = SEL_W'((d < en_at) ? cur : tgt);
          exp_rdy[d] = 1'b0;
          exp_sw[d]  = 1'b1;
        end
        exp_done[done_at] = 1'b1;
        exp_err[done_at]  = fb;
        cur = tgt;
        c = done_at;
      end else begin
        c++;
      end
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 3'd2, 1'b0, 1'b0, 4'b0001, 3'd0};
    vecs[1] = '{1'b1, 3'd0, 1'b1, 1'b0, 4'b0001, 3'd0};
    vecs[2] = '{1'b1, 3'd5, 1'b0, 1'b1, 4'b0001, 3'd0};
    vecs[3] = '{1'b1, 3'd7, 1'b0, 1'b1, 4'b0001, 3'd0};
    vecs[4] = '{1'b1, 3'd4, 1'b0, 1'b1, 4'b0001, 3'd0};
    vecs[5] = '{1'b0, 3'd6, 1'b0, 1'b0, 4'b0001, 3'd0};
    vecs[6] = '{1'b1, 3'd0, 1'b1, 1'b0, 4'b0001, 3'd0};

    // Reset state
    CLK_OK = 4'hF;
    do_reset();
    chk("rst.en", 32'(CLK_EN), 32'(4'b0001));
    chk("rst.cur", 32'(CUR_SEL), 32'(0));
    chk("rst.rdy", 32'(REQ_READY), 32'(1));
    chk("rst.sw", 32'(SWITCHING), 32'(0));
    chk("rst.done", 32'(DONE), 32'(0));
    chk("rst.err", 32'(ERR), 32'(0));

    // Single-cycle idle requests
    for (int i = 0; i < 7; i++) begin
      REQ_VALID = vecs[i].vld;
      REQ_SEL = vecs[i].sel;
      @(negedge CLK);
      REQ_VALID = 1'b0;
      chk($sformatf("vec%0d.done", i), 32'(DONE), 32'(vecs[i].done));
      chk($sformatf("vec%0d.err", i), 32'(ERR), 32'(vecs[i].err));
      chk($sformatf("vec%0d.en", i), 32'(CLK_EN), 32'(vecs[i].en));
      chk($sformatf("vec%0d.cur", i), 32'(CUR_SEL), 32'(vecs[i].cur));
      chk($sformatf("vec%0d.rdy", i), 32'(REQ_READY), 32'(1));
    end

    // Normal switch to 2
    run_switch("sw2", 2, 2, OFFC + 2, OFFC + ONC + 2, 1'b0, -1);

    // Same-source request
    REQ_VALID = 1'b1; REQ_SEL = 3'd2;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    chk("same.done", 32'(DONE), 32'(1));
    chk("same.err", 32'(ERR), 32'(0));
    chk("same.en", 32'(CLK_EN), 32'(4'b0100));

    // Invalid request
    REQ_VALID = 1'b1; REQ_SEL = 3'd5;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    chk("bad.err", 32'(ERR), 32'(1));
    chk("bad.done", 32'(DONE), 32'(0));
    chk("bad.en", 32'(CLK_EN), 32'(4'b0100));
    chk("bad.cur", 32'(CUR_SEL), 32'(2));

    // Back to 0, then timeout fallback on a request for 3
    run_switch("sw0", 0, 0, OFFC + 2, OFFC + ONC + 2, 1'b0, -1);
    CLK_OK = 4'b0111;
    run_switch("to3", 3, 0, OFFC + TO + 1, OFFC + TO + ONC + 1, 1'b1, -1);
    CLK_OK = 4'hF;

    // Late health: CLK_OK[1] rises 20 cycles into WAIT_OK
    CLK_OK = 4'b1101;
    run_switch("late1", 1, 1, OFFC + 1 + 20 + 1, OFFC + 1 + 20 + 1 + ONC, 1'b0, OFFC + 1 + 20);
    CLK_OK = 4'hF;

    // Reset during OFF
    REQ_VALID = 1'b1; REQ_SEL = 3'd2;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      REQ_VALID = 1'b0;
    end
    chk("rmid.en_off", 32'(CLK_EN), 32'(0));
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("rmid.en", 32'(CLK_EN), 32'(4'b0001));
    chk("rmid.rdy", 32'(REQ_READY), 32'(1));
    chk("rmid.sw", 32'(SWITCHING), 32'(0));
    chk("rmid.cur", 32'(CUR_SEL), 32'(0));

    // Random run against the timeline model; starts from the reset state.
    ok_t[0] = 4'hF;
    for (int i = 0; i < NA; i++) begin
      if (i > 0) begin
        ok_t[i] = ok_t[i-1];
        for (int b = 0; b < NUM_CLK; b++)
          if ($urandom_range(0, 49) == 0) ok_t[i][b] = ~ok_t[i][b];
      end
      vld_t[i] = (i < N - 200) && ($urandom_range(0, 2) == 0);
      sel_t[i] = SEL_W'($urandom_range(0, 5));
    end
    build_model();
    for (int c = 0; c < N; c++) begin
      chk($sformatf("rnd[%0d].en", c), 32'(CLK_EN), 32'(exp_en[c]));
      chk($sformatf("rnd[%0d].cur", c), 32'(CUR_SEL), 32'(exp_cur[c]));
      chk($sformatf("rnd[%0d].rdy", c), 32'(REQ_READY), 32'(exp_rdy[c]));
      chk($sformatf("rnd[%0d].sw", c), 32'(SWITCHING), 32'(exp_sw[c]));
      chk($sformatf("rnd[%0d].done", c), 32'(DONE), 32'(exp_done[c]));
      chk($sformatf("rnd[%0d].err", c), 32'(ERR), 32'(exp_err[c]));
      REQ_VALID = vld_t[c];
      REQ_SEL = sel_t[c];
      CLK_OK = ok_t[c];
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
